instr_encoder_loader: RTL and testbench

//  Packs decoded fields (opcode, regs, funct, immediate) into 32-bit RV32 instruction words and writes them to instruction memory.
//  It is the inverse of the immediate extension unit: it puts imm bits into I/S/R-format positions instead of extracting them.
//  It is a boot/test loader that sits between the bench or debug port and the IF-stage instruction memory.
//  It accepts fields over a valid/ready handshake, range-checks the immediate, and writes words at auto-incrementing addresses.

---
 rtl/rv_enc_pkg.sv | 32 +++
 rtl/instr_encoder_loader_imm_pack.sv | 46 ++++
 rtl/instr_encoder_loader.sv | 131 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32 instruction encoder/loader.
// Includes the immediate re-extraction helper used by the optional self-check.
package rv_enc_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [1:0] FMT_IU = 2'b00;
  localparam logic [1:0] FMT_IS = 2'b01;
  localparam logic [1:0] FMT_R  = 2'b10;
  localparam logic [1:0] FMT_S  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } enc_state_e;

  // Same rules as the extension unit: the image of a packed word's immediate.
  function automatic logic [INSTR_W-1:0] imm_extract(input logic [1:0] fmt,
                                                     input logic [INSTR_W-1:0] word);
    logic [INSTR_W-1:0] v;
    v = '0;
    case (fmt)
      FMT_IU:  v = {20'd0, word[31:20]};
      FMT_IS:  v = {{20{word[31]}}, word[31:20]};
      FMT_S:   v = {{20{word[31]}}, word[31:25], word[11:7]};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_imm_pack.sv
// Combinational packer: places decoded fields and immediate into an RV32
// I/R/S word and reports whether the immediate fits the chosen format.
module imm_pack
  import rv_enc_pkg::*;
(
  input  logic [1:0]         i_fmt,
  input  logic [6:0]         i_opcode,
  input  logic [4:0]         i_rd,
  input  logic [2:0]         i_funct3,
  input  logic [4:0]         i_rs1,
  input  logic [4:0]         i_rs2,
  input  logic [6:0]         i_funct7,
  input  logic [INSTR_W-1:0] i_imm,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_in_range
);

  logic w_sext_ok;

  // Signed 12-bit fit: bits 31..11 all copies of the sign bit.
  assign w_sext_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);

  always_comb begin
    o_word     = '0;
    o_in_range = 1'b1;
    case (i_fmt)
      FMT_IU: begin
        o_word     = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_in_range = ~(|i_imm[31:12]);
      end
      FMT_IS: begin
        o_word     = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_in_range = w_sext_ok;
      end
      FMT_R: begin
        o_word     = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        o_in_range = 1'b1;
      end
      default: begin
        o_word     = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        o_in_range = w_sext_ok;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test loader: packs field bundles into RV32 words and writes them to
// instruction memory at auto-incrementing addresses. Optional: ENC_SELFCHECK_EN.
module instr_encoder_loader
  import rv_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              range_err,
  output logic [7:0]        err_cnt,
  output logic              full
`ifdef ENC_SELFCHECK_EN
  , output logic            selfcheck_err
`endif
);

  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;

  enc_state_e          r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [7:0]          r_err_cnt;
  logic                r_mem_we, r_range_err;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [INSTR_W-1:0]  r_mem_wdata;
  logic [INSTR_W-1:0]  w_word;
  logic                w_in_range, w_acc, w_legal, w_illegal, w_start, w_finish;

  imm_pack u_imm_pack (
    .i_fmt      (fmt),
    .i_opcode   (opcode),
    .i_rd       (rd),
    .i_funct3   (funct3),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_funct7   (funct7),
    .i_imm      (imm),
    .o_word     (w_word),
    .o_in_range (w_in_range)
  );

  assign in_ready  = (r_state == LOAD);
  assign full      = (r_state == FULL);
  assign w_acc     = in_valid & in_ready;
  assign w_legal   = w_acc & w_in_range;
  assign w_illegal = w_acc & ~w_in_range;
  // finish wins over start, so a simultaneous start never opens/restarts a session.
  assign w_finish  = finish & (r_state != IDLE);
  assign w_start   = start & ~finish;

  always_comb begin
    w_state_nxt = r_state;
    if (w_finish)                                           w_state_nxt = IDLE;
    else if (w_start)                                       w_state_nxt = LOAD;
    else if ((r_state == LOAD) && w_legal && (r_ptr == PTR_MAX)) w_state_nxt = FULL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= PTR_BASE;
      r_err_cnt   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_range_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_we    <= w_legal;
      r_range_err <= w_illegal;
      if (w_legal) begin
        r_mem_addr  <= r_ptr;
        r_mem_wdata <= w_word;
      end
      if (w_start)                              r_ptr <= PTR_BASE;
      else if (w_legal && (r_ptr != PTR_MAX))   r_ptr <= r_ptr + 1'b1;
      if (w_start)                              r_err_cnt <= '0;
      else if (w_illegal && (r_err_cnt != '1))  r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign range_err = r_range_err;
  assign err_cnt   = r_err_cnt;

`ifdef ENC_SELFCHECK_EN
  logic [1:0]         r_chk_fmt;
  logic [INSTR_W-1:0] r_chk_imm;
  logic               r_selfcheck_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_fmt       <= FMT_R;
      r_chk_imm       <= '0;
      r_selfcheck_err <= 1'b0;
    end else begin
      if (w_legal) begin
        r_chk_fmt <= fmt;
        r_chk_imm <= imm;
      end
      if (w_start)
        r_selfcheck_err <= 1'b0;
      else if (r_mem_we && (r_chk_fmt != FMT_R) &&
               (imm_extract(r_chk_fmt, r_mem_wdata) != r_chk_imm))
        r_selfcheck_err <= 1'b1;
    end
  end

  assign selfcheck_err = r_selfcheck_err;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader (ADDR_W=2) against
// an arithmetic reference model of the packing, range and session rules.
module tb_instr_encoder_loader;

  localparam int unsigned AW   = 2;
  localparam int unsigned BASE = 0;
  localparam int unsigned MAXA = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    fmt = '0;
  logic [6:0]    opcode = '0, funct7 = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [31:0]   imm = '0;
  logic          mem_we, range_err, full;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [7:0]    err_cnt;
`ifdef ENC_SELFCHECK_EN
  logic          selfcheck_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit m_open = 0, m_full = 0;
  int m_ptr = BASE;
  int m_err = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .finish    (finish),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct7    (funct7),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .range_err (range_err),
    .err_cnt   (err_cnt),
    .full      (full)
`ifdef ENC_SELFCHECK_EN
    , .selfcheck_err (selfcheck_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit fits(input logic [1:0] f, input logic [31:0] im);
    int s;
    s = $signed(im);
    case (f)
      2'b00:   return im < 32'd4096;
      2'b10:   return 1'b1;
      default: return (s >= -2048) && (s <= 2047);
    endcase
  endfunction

  function automatic logic [31:0] pack(input logic [1:0] f, input logic [6:0] op,
                                       input logic [4:0] d, input logic [2:0] f3,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] low;
    low = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    case (f)
      2'b10:   return (32'(f7) << 25) | (32'(s2) << 20) | (32'(d) << 7) | low;
      2'b11:   return (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | ((im & 32'h1F) << 7) | low;
      default: return ((im & 32'hFFF) << 20) | (32'(d) << 7) | low;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the clock, and compare with the model.
  task automatic step(input bit st, input bit fi, input bit v, input logic [1:0] f,
                      input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                      input logic [31:0] im);
    bit acc, legal;
    int exp_addr;
    logic [31:0] exp_word;
    start = st; finish = fi; in_valid = v; fmt = f; opcode = op; rd = d;
    funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
    acc      = v && m_open && !m_full;
    legal    = acc && fits(f, im);
    exp_addr = m_ptr;
    exp_word = pack(f, op, d, f3, s1, s2, f7, im);
    @(posedge clk); #1;
    if (fi && m_open) begin
      m_open = 0; m_full = 0;
    end else if (st && !fi) begin
      m_open = 1; m_full = 0;
    end else if (legal && exp_addr == MAXA) begin
      m_full = 1;
    end
    if (st && !fi) m_ptr = BASE;
    else if (legal && m_ptr < MAXA) m_ptr++;
    if (st && !fi) m_err = 0;
    else if (acc && !legal && m_err < 255) m_err++;
    check_eq("mem_we", 32'(mem_we), 32'(legal));
    check_eq("range_err", 32'(range_err), 32'(acc && !legal));
    check_eq("err_cnt", 32'(err_cnt), 32'(m_err));
    check_eq("full", 32'(full), 32'(m_full));
    check_eq("in_ready", 32'(in_ready), 32'(m_open && !m_full));
    if (legal) begin
      check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check_eq("mem_wdata", mem_wdata, exp_word);
    end
`ifdef ENC_SELFCHECK_EN
    check_eq("selfcheck_err", 32'(selfcheck_err), 32'd0);
`endif
  endtask

  task automatic idle_step(input bit st, input bit fi);
    step(st, fi, 1'b0, 2'b10, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges [7];
    edges = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4095, 32'd4096, 32'd0};
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       return 32'($urandom_range(0, 4095));
      2:       return $urandom();
      default: return edges[$urandom_range(0, 6)];
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_range_err", 32'(range_err), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // addi x1,x0,-1 ; sw x2,8(x1)
    idle_step(1'b1, 1'b0);
    step(0, 0, 1, 2'b01, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
    check_eq("tc1_word", mem_wdata, 32'hFFF00093);
    check_eq("tc1_addr", 32'(mem_addr), 32'd0);
    step(0, 0, 1, 2'b11, 7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd8);
    check_eq("tc2_word", mem_wdata, 32'h0020A423);
    check_eq("tc2_addr", 32'(mem_addr), 32'd1);

    // out-of-range signed immediate, then max unsigned immediate
    step(0, 0, 1, 2'b01, 7'b0010011, 5'd3, 3'd0, 5'd4, 5'd0, 7'd0, 32'd2048);
    check_eq("tc3_range_err", 32'(range_err), 32'd1);
    check_eq("tc3_err_cnt", 32'(err_cnt), 32'd1);
    step(0, 0, 1, 2'b00, 7'b0010011, 5'd3, 3'd3, 5'd4, 5'd0, 7'd0, 32'd4095);
    check_eq("tc3_addr", 32'(mem_addr), 32'd2);

    // fill all four addresses back to back
    idle_step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 2'b10, 7'b0110011, 5'(i), 3'(i), 5'(i + 1), 5'(i + 2), 7'h20, 32'd0);
    check_eq("tc4_full", 32'(full), 32'd1);
    step(0, 0, 1, 2'b10, 7'b0110011, 5'd9, 3'd1, 5'd2, 5'd3, 7'd0, 32'd0);
    idle_step(1'b0, 1'b1);

    // start+finish together in LOAD closes session; held valid is not accepted
    idle_step(1'b1, 1'b0);
    step(0, 0, 1, 2'b01, 7'b0010011, 5'd5, 3'd0, 5'd6, 5'd0, 7'd0, 32'd7);
    step(1, 1, 1, 2'b01, 7'b0010011, 5'd5, 3'd0, 5'd6, 5'd0, 7'd0, 32'd9);
    step(0, 0, 1, 2'b01, 7'b0010011, 5'd5, 3'd0, 5'd6, 5'd0, 7'd0, 32'd11);
    check_eq("tc5_in_ready", 32'(in_ready), 32'd0);

    // error counter saturation
    idle_step(1'b1, 1'b0);
    for (int i = 0; i < 260; i++)
      step(0, 0, 1, 2'b00, 7'b0010011, 5'd1, 3'd0, 5'd1, 5'd0, 7'd0, 32'd4096 + 32'(i));
    check_eq("sat_err_cnt", 32'(err_cnt), 32'd255);

    // randomized traffic
    idle_step(1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      bit st, fi;
      st = m_open ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
      fi = ($urandom_range(0, 39) == 0);
      step(st, fi, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           7'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()),
           5'($urandom()), 7'($urandom()), rand_imm());
    end

    // async reset between edges with a write in flight
    idle_step(1'b1, 1'b0);
    step(0, 0, 1, 2'b01, 7'b0010011, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'd100);
    check_eq("tc6_pending_we", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("tc6_mem_we", 32'(mem_we), 32'd0);
    check_eq("tc6_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("tc6_mem_wdata", mem_wdata, 32'd0);
    check_eq("tc6_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("tc6_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_open = 0; m_full = 0; m_ptr = BASE; m_err = 0;
    step(0, 0, 1, 2'b01, 7'b0010011, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
